uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYS_CLK_FRE, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BPS, default 9_600, baud rate; derived BPS_CNT = SYS_CLK_FRE/BPS (5208 at defaults).
REQ-003 SHALL have port sys_clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port uart_data  output  8  last correctly framed byte.
REQ-007 SHALL have port uart_done  output  1  one-cycle pulse when uart_data updates.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port direction  output  3  snake direction decoded from received keys.

Function
REQ-011 SHALL pass uart_rxd through a 2-flop synchronizer; all decisions use the synchronized signal rx_s.
REQ-012 SHALL implement the states IDLE, START, DATA and STOP; clk_cnt counts 0..BPS_CNT-1 within each bit, and bit_cnt counts 0..7.
REQ-013 IDLE: a 1->0 transition on rx_s SHALL enter START with clk_cnt=0.
REQ-014 START: at clk_cnt==BPS_CNT/2-1 the start bit SHALL be sampled; low -> DATA with clk_cnt=0; high -> IDLE (false start, no outputs pulsed).
REQ-015 DATA: at each clk_cnt==BPS_CNT-1 one bit SHALL be sampled, LSB first, into a shift register; after bit_cnt 7 the block SHALL go to STOP.
REQ-016 STOP: at clk_cnt==BPS_CNT-1 the stop bit SHALL be sampled; high -> uart_data<=shift register and uart_done pulsed; low -> frame_err pulsed and uart_data unchanged; both cases SHALL return to IDLE in the same cycle.
REQ-017 uart_done and frame_err SHALL be registered, high for exactly one cycle, and never high together.
REQ-018 Latency from the uart_rxd falling edge to uart_done SHALL be 2 + BPS_CNT/2 + 9*BPS_CNT cycles, ±2.
REQ-019 Returning to IDLE at the middle of the stop bit SHALL allow a back-to-back frame (next start edge within half a bit) to be received without loss.
REQ-020 direction SHALL update only in the cycle that uart_done asserts: 'w'/'W' -> 3'd1 (up), 's'/'S' -> 3'd2 (down), 'a'/'A' -> 3'd3 (left), 'd'/'D' -> 3'd4 (right); any other byte or a frame error SHALL leave it unchanged.
REQ-021 uart_rxd held low indefinitely (break) SHALL produce frame_err once, then the block SHALL stay in IDLE until rx_s has returned high and fallen again.

Reset
REQ-022 While sys_rst is high: state=IDLE, clk_cnt=0, bit_cnt=0, shift register=0, uart_data=8'd0, uart_done=0, frame_err=0, busy=0, direction=3'd0, synchronizer flops=1.
REQ-023 A reset asserted mid-frame SHALL abort the frame with no uart_done or frame_err pulse; reception SHALL restart only on a fresh falling edge after reset.

Configuration
REQ-024 With UART_RX_MAJORITY_EN defined, each sample (start, data, stop) SHALL be the 2-of-3 majority of rx_s at the sample cycle and the two cycles before it.
REQ-025 Without UART_RX_MAJORITY_EN, each sample SHALL be the single value of rx_s at the sample cycle.
REQ-026 Timing, latency and outputs SHALL be identical in both builds.

Structure
REQ-027 Package uart_pkg SHALL hold the rx state enum, the direction codes (DIR_NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4) and the default SYS_CLK_FRE/BPS constants.
REQ-028 The synchronizer SHALL be a separate sub-module, uart_rx_sync (2 flops, reset value 1).

Verification
REQ-029 Frame 0x55 at 9600 bps -> uart_data=0x55, a single uart_done pulse within ±2 cycles of REQ-018, frame_err stays 0.
REQ-030 Frame 0x77 ('w') -> direction=3'd1; then 0x41 ('A') -> direction=3'd3; then 0x31 -> direction stays 3'd3.
REQ-031 Frame 0x64 with stop bit 0 -> frame_err one pulse, no uart_done, uart_data and direction unchanged.
REQ-032 Low glitch of 1000 cycles on an idle line -> false start, busy returns low, no pulses.
REQ-033 Back-to-back 'a','d' with zero idle gap -> two uart_done pulses, direction 3'd3 then 3'd4.
REQ-034 sys_rst during bit 4 of a frame -> no pulses, all outputs at reset values; next frame 0xA5 is received correctly. With UART_RX_MAJORITY_EN, a 1-cycle inverted glitch at a data sample point -> byte still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver slice.
// Holds the receiver state encoding, snake direction codes, default clock and
// baud constants, and the key-to-direction decoder.
package uart_pkg;

  localparam int DEF_SYS_CLK_FRE = 50_000_000;
  localparam int DEF_BPS         = 9_600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  // Map a received key to a direction; unknown keys keep the current heading.
  function automatic logic [2:0] dir_decode(input logic [7:0] key,
                                            input logic [2:0] cur);
    logic [2:0] res;
    case (key)
      8'h77, 8'h57: res = DIR_UP;     // 'w' / 'W'
      8'h73, 8'h53: res = DIR_DOWN;   // 's' / 'S'
      8'h61, 8'h41: res = DIR_LEFT;   // 'a' / 'A'
      8'h64, 8'h44: res = DIR_RIGHT;  // 'd' / 'D'
      default:      res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so a reset looks like an idle (high) line.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the raw line through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with snake-direction key decoding.
// Samples the start bit at mid-bit, then each data and stop bit one bit period
// later, returning to IDLE at mid-stop so back-to-back frames are not lost.
// Optional build macro: UART_RX_MAJORITY_EN -- each sample becomes the 2-of-3
// majority of the synchronized line over the sample cycle and the two before it.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FRE = DEF_SYS_CLK_FRE,
  parameter int BPS         = DEF_BPS
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] direction
);

  localparam int BPS_CNT = SYS_CLK_FRE / BPS;
  localparam int CNT_W   = $clog2(BPS_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             rx_s;
  logic             rx_d1_q, rx_d1_d;
  logic             sample_s;
  logic             fall_s;
  logic             busy_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       uart_data_q, uart_data_d;
  logic             uart_done_q, uart_done_d;
  logic             frame_err_q, frame_err_d;
  logic [2:0]       direction_q, direction_d;

  uart_rx_sync u_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (uart_rxd),
    .q   (rx_s)
  );

  // One-cycle history of the synchronized line, used for edge detection.
  always_comb begin
    rx_d1_d = rx_s;
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2_q, rx_d2_d;

  // Second history stage, only needed for the majority vote.
  always_comb begin
    rx_d2_d = rx_d1_q;
  end

  // Second history flop, reset to the idle level.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_d2_q <= 1'b1;
    end else begin
      rx_d2_q <= rx_d2_d;
    end
  end

  assign sample_s = (rx_s & rx_d1_q) | (rx_s & rx_d2_q) | (rx_d1_q & rx_d2_q);
`else
  assign sample_s = rx_s;
`endif

  assign fall_s = rx_d1_q & ~rx_s;

  // State register and datapath flops; reset aborts any frame in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_d1_q     <= 1'b1;
      state_q     <= ST_IDLE;
      clk_cnt_q   <= CNT_ZERO;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      uart_data_q <= 8'd0;
      uart_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      direction_q <= DIR_NONE;
    end else begin
      rx_d1_q     <= rx_d1_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      uart_data_q <= uart_data_d;
      uart_done_q <= uart_done_d;
      frame_err_q <= frame_err_d;
      direction_q <= direction_d;
    end
  end

  // Next-state and datapath update: bit timing, shifting and frame checking.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    uart_data_d = uart_data_q;
    uart_done_d = 1'b0;
    frame_err_d = 1'b0;
    direction_d = direction_q;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = CNT_ZERO;
        bit_cnt_d = 3'd0;
        if (fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (clk_cnt_q == CNT_MID) begin
          clk_cnt_d = CNT_ZERO;
          // A start bit that is high again by mid-bit was only a glitch.
          if (!sample_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = CNT_ZERO;
          shift_d   = {sample_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          // Leave at mid-stop so the next start edge is caught immediately.
          clk_cnt_d = CNT_ZERO;
          state_d   = ST_IDLE;
          if (sample_s) begin
            uart_data_d = shift_q;
            uart_done_d = 1'b1;
            direction_d = dir_decode(shift_q, direction_q);
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = CNT_ZERO;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Output decode: busy whenever a frame is being tracked.
  always_comb begin
    if (state_q != ST_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  assign busy      = busy_s;
  assign uart_data = uart_data_q;
  assign uart_done = uart_done_q;
  assign frame_err = frame_err_q;
  assign direction = direction_q;

endmodule
